// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared types and helpers for the sequential binary-to-BCD converter.
//   bcd_digit_t         one packed BCD nibble
//   bin_to_bcd_state_t  converter FSM states (IDLE, SHIFT, DONE)
//   BCD_NINE            digit value used when a result saturates
//   add3_adjust()       double-dabble correction for a single digit
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bin_to_bcd_state_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // A digit of 5 or more would become >= 10 after the next left shift,
  // so it is pre-biased by 3 to make the shift carry into the next digit.
  function automatic bcd_digit_t add3_adjust(input bcd_digit_t digit);
    if (digit >= 4'd5) begin
      return digit + 4'd3;
    end
    return digit;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Combinational add-3 correction for one BCD digit of the double-dabble
// accumulator. One instance is used per digit.
// Ports:
//   digit_in   current accumulator digit
//   digit_out  digit after the add-3 correction (digit + 3 when >= 5)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = add3_adjust(digit_in);

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential double-dabble converter: turns an unsigned BIN_WIDTH-bit value
// into NUM_DIGITS packed BCD digits, one shift step per clock, and presents
// the result (plus its decimal-point bits) to the display stage. Results are
// held stable until the next conversion completes.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits produced (matches display NUM_SEGMENTS)
//   BIN_WIDTH   width of bin_in; also the number of shift cycles
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   bin_in       value to convert, sampled on acceptance
//   dp_in        decimal-point bits, sampled on acceptance
//   in_valid     request; accepted when in_valid && in_ready
//   in_ready     high only while idle
//   encoded      registered BCD result, digit 0 is least significant
//   digit_point  registered dp bits belonging to encoded
//   out_valid    one-cycle pulse when a new result first appears
//   overflow     registered; result did not fit in NUM_DIGITS digits
//
// Configuration macro BIN_TO_BCD_SATURATE_EN:
//   defined     out-of-range values give all 9s and overflow = 1
//   undefined   encoded = value mod 10^NUM_DIGITS, overflow stays 0
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BIN_WIDTH-1:0]       bin_in,
  input  logic [NUM_DIGITS-1:0]      dp_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_DIGITS-1:0][3:0] encoded,
  output logic [NUM_DIGITS-1:0]      digit_point,
  output logic                       out_valid,
  output logic                       overflow
);

  localparam int ACC_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_WIDTH - 1);

  bin_to_bcd_state_t state;
  bin_to_bcd_state_t state_next;

  logic [BIN_WIDTH-1:0]  shift_reg;
  logic [NUM_DIGITS-1:0] dp_hold;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_adj;
  logic [CNT_W-1:0]      count;

  // Every digit gets its add-3 correction in parallel before the shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_in  (acc[g*4 +: 4]),
      .digit_out (acc_adj[g*4 +: 4])
    );
  end

`ifdef BIN_TO_BCD_SATURATE_EN
  // Any bit pushed out of the top digit means the value is >= 10^NUM_DIGITS.
  logic sticky_carry;
`else
  // The top digit's carry-out is simply dropped, which leaves the lower
  // digits holding value mod 10^NUM_DIGITS.
  logic unused_carry;
  assign unused_carry = acc_adj[ACC_W-1];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the ready flag.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST_COUNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Conversion datapath and registered outputs. Outputs change only in
  // DONE, so they stay stable for the display stage between conversions.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg    <= '0;
      dp_hold      <= '0;
      acc          <= '0;
      count        <= '0;
      encoded      <= '0;
      digit_point  <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
`ifdef BIN_TO_BCD_SATURATE_EN
      sticky_carry <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg    <= bin_in;
            dp_hold      <= dp_in;
            acc          <= '0;
            count        <= '0;
`ifdef BIN_TO_BCD_SATURATE_EN
            sticky_carry <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          acc          <= {acc_adj[ACC_W-2:0], shift_reg[BIN_WIDTH-1]};
          shift_reg    <= shift_reg << 1;
          count        <= count + 1'b1;
`ifdef BIN_TO_BCD_SATURATE_EN
          sticky_carry <= sticky_carry | acc_adj[ACC_W-1];
`endif
        end
        DONE: begin
          digit_point <= dp_hold;
          out_valid   <= 1'b1;
`ifdef BIN_TO_BCD_SATURATE_EN
          if (sticky_carry) begin
            encoded  <= {NUM_DIGITS{BCD_NINE}};
            overflow <= 1'b1;
          end else begin
            encoded  <= acc;
            overflow <= 1'b0;
          end
`else
          encoded <= acc;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq (default parameters). A latency /
// decimal-arithmetic model predicts every output each cycle; directed tests
// add literal expectations for specific conversions.
module tb_bin_to_bcd_seq;

  localparam int NUM_DIGITS = 2;
  localparam int BIN_WIDTH  = 8;
  localparam int ENC_W      = NUM_DIGITS * 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [BIN_WIDTH-1:0]       bin_in;
  logic [NUM_DIGITS-1:0]      dp_in;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_DIGITS-1:0][3:0] encoded;
  logic [NUM_DIGITS-1:0]      digit_point;
  logic                       out_valid;
  logic                       overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bin_to_bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_WIDTH  (BIN_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bin_in      (bin_in),
    .dp_in       (dp_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .encoded     (encoded),
    .digit_point (digit_point),
    .out_valid   (out_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected BCD from plain decimal arithmetic.
  function automatic logic [ENC_W-1:0] model_enc(input int v);
    logic [ENC_W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef BIN_TO_BCD_SATURATE_EN
    if (v >= p) begin
      for (int i = 0; i < NUM_DIGITS; i++) r[i*4 +: 4] = 4'd9;
    end
`endif
    return r;
  endfunction

  function automatic logic model_ov(input int v);
`ifdef BIN_TO_BCD_SATURATE_EN
    int p;
    p = 1;
    for (int i = 0; i < NUM_DIGITS; i++) p = p * 10;
    return (v >= p);
`else
    return (v < 0);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: a busy window of BIN_WIDTH+1 edges after acceptance, then the
  // decimal result appears with a one-cycle valid pulse.
  logic             m_live = 1'b0;
  logic             m_busy;
  int               m_left;
  int               m_val;
  logic [1:0]       m_pdp;
  logic [ENC_W-1:0] m_enc;
  logic [1:0]       m_dp;
  logic             m_ov;
  logic             m_pulse;

  always @(posedge clk) begin
    if (reset) begin
      m_live  <= 1'b1;
      m_busy  <= 1'b0;
      m_left  <= 0;
      m_enc   <= '0;
      m_dp    <= '0;
      m_ov    <= 1'b0;
      m_pulse <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_enc   <= model_enc(m_val);
          m_dp    <= m_pdp;
          m_ov    <= model_ov(m_val);
          m_pulse <= 1'b1;
        end
        m_left <= m_left - 1;
      end else if (in_valid) begin
        m_busy <= 1'b1;
        m_left <= BIN_WIDTH + 1;
        m_val  <= int'(bin_in);
        m_pdp  <= dp_in;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("in_ready",    32'(in_ready),    32'(!m_busy));
      checkOutput("out_valid",   32'(out_valid),   32'(m_pulse));
      checkOutput("encoded",     32'(encoded),     32'(m_enc));
      checkOutput("digit_point", 32'(digit_point), 32'(m_dp));
      checkOutput("overflow",    32'(overflow),    32'(m_ov));
    end
  end

  int acc_cyc;
  int p1;
  int p2;
  logic seen;

  // Drive one request for a single accepted cycle (caller ensures idle).
  task automatic applyStimulus(input logic [BIN_WIDTH-1:0] v, input logic [1:0] dp);
    @(negedge clk);
    #1;
    bin_in   = v;
    dp_in    = dp;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic waitPulse(input int budget, output int pcyc, output logic got);
    got  = 1'b0;
    pcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got  = 1'b1;
        pcyc = cyc;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [BIN_WIDTH-1:0] vecs [6];
    int pulse_count;
    vecs = '{8'd9, 8'd10, 8'd100, 8'd199, 8'd250, 8'd1};

    // Pin the model against hand-computed values.
    checkOutput("model_42", 32'(model_enc(42)), 32'h42);
    checkOutput("model_7",  32'(model_enc(7)),  32'h07);
`ifdef BIN_TO_BCD_SATURATE_EN
    checkOutput("model_255", 32'(model_enc(255)), 32'h99);
    checkOutput("model_100", 32'(model_enc(100)), 32'h99);
`else
    checkOutput("model_255", 32'(model_enc(255)), 32'h55);
    checkOutput("model_100", 32'(model_enc(100)), 32'h00);
`endif

    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    dp_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_encoded",  32'(encoded),  32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);

    // 42 with dp 01: result after 9 edges.
    applyStimulus(8'd42, 2'b01);
    waitPulse(20, p1, seen);
    checkOutput("t1_pulse",   32'(seen), 32'h1);
    checkOutput("t1_latency", 32'(p1 - acc_cyc), 32'd9);
    checkOutput("t1_enc",     32'(encoded), 32'h42);
    checkOutput("t1_dp",      32'(digit_point), 32'h1);
    checkOutput("t1_ov",      32'(overflow), 32'h0);
    @(negedge clk);
    checkOutput("t1_pulse_len", 32'(out_valid), 32'h0);

    // 0 then 99 back to back with in_valid held high.
    #1;
    bin_in   = 8'd0;
    dp_in    = 2'b10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_in = 8'd99;
    dp_in  = 2'b11;
    waitPulse(20, p1, seen);
    checkOutput("t2_pulse0", 32'(seen), 32'h1);
    checkOutput("t2_enc0",   32'(encoded), 32'h00);
    waitPulse(20, p2, seen);
    #1;
    in_valid = 1'b0;
    checkOutput("t2_pulse99", 32'(seen), 32'h1);
    checkOutput("t2_enc99",   32'(encoded), 32'h99);
    checkOutput("t2_spacing", 32'(p2 - p1), 32'd10);
    repeat (2) @(posedge clk);

    // 255: out of range for two digits.
    applyStimulus(8'd255, 2'b00);
    waitPulse(20, p1, seen);
    checkOutput("t3_pulse", 32'(seen), 32'h1);
`ifdef BIN_TO_BCD_SATURATE_EN
    checkOutput("t3_enc", 32'(encoded), 32'h99);
    checkOutput("t3_ov",  32'(overflow), 32'h1);
`else
    checkOutput("t3_enc", 32'(encoded), 32'h55);
    checkOutput("t3_ov",  32'(overflow), 32'h0);
`endif

    // Request while busy is ignored.
    applyStimulus(8'd42, 2'b10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    bin_in   = 8'd17;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t4_busy", 32'(in_ready), 32'h0);
    waitPulse(20, p1, seen);
    checkOutput("t4_pulse", 32'(seen), 32'h1);
    checkOutput("t4_enc",   32'(encoded), 32'h42);
    checkOutput("t4_dp",    32'(digit_point), 32'h2);

    // Reset in the middle of a conversion aborts it.
    applyStimulus(8'd42, 2'b01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_enc",   32'(encoded), 32'h0);
    checkOutput("t5_ready", 32'(in_ready), 32'h1);
    pulse_count = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulse_count++;
    end
    checkOutput("t5_no_pulse", 32'(pulse_count), 32'h0);
    applyStimulus(8'd7, 2'b00);
    waitPulse(20, p1, seen);
    checkOutput("t5_pulse7", 32'(seen), 32'h1);
    checkOutput("t5_enc7",   32'(encoded), 32'h07);

    // Reset wins over a same-cycle request.
    @(negedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    bin_in   = 8'd33;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    checkOutput("t6_ready", 32'(in_ready), 32'h1);

    // A few more boundary values against the model.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], 2'(k));
      waitPulse(20, p1, seen);
      checkOutput("tv_pulse", 32'(seen), 32'h1);
      checkOutput("tv_enc",   32'(encoded), 32'(model_enc(int'(vecs[k]))));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
